// File: rtl/id_operand_stage.sv
// ID-stage operand resolver across NUM_FWD forwarding channels, with load-use hazard detection.
// Registers the result into the ID/EX pipeline register with one cycle of latency.
module id_operand_stage #(
  parameter int DW          = 32,
  parameter int AW          = 5,
  parameter int OPW         = 8,
  parameter int SELW        = 3,
  parameter int NUM_FWD     = 2,
  parameter int LOAD_STAGES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [31:0]           id_pc,
  input  logic                  reg1_rd_en,
  input  logic                  reg2_rd_en,
  input  logic [AW-1:0]         reg1_addr,
  input  logic [AW-1:0]         reg2_addr,
  input  logic [DW-1:0]         reg1_data,
  input  logic [DW-1:0]         reg2_data,
  input  logic [DW-1:0]         imm,
  input  logic [OPW-1:0]        dec_aluop,
  input  logic [SELW-1:0]       dec_alusel,
  input  logic [AW-1:0]         dec_waddr,
  input  logic                  dec_wr_en,
  input  logic                  dec_is_load,
  input  logic [NUM_FWD-1:0]    fwd_wr_en,
  input  logic [NUM_FWD-1:0]    fwd_is_load,
  input  logic [NUM_FWD*AW-1:0] fwd_waddr,
  input  logic [NUM_FWD*DW-1:0] fwd_wdata,
  input  logic                  ex_stall,
  input  logic                  flush,
  output logic                  stall_req,
  output logic                  id_ready,
  output logic                  ex_valid,
  output logic [31:0]           ex_pc,
  output logic [DW-1:0]         ex_reg1,
  output logic [DW-1:0]         ex_reg2,
  output logic [OPW-1:0]        ex_aluop,
  output logic [SELW-1:0]       ex_alusel,
  output logic [AW-1:0]         ex_waddr,
  output logic                  ex_wr_en,
  output logic                  ex_is_load,
  output logic [15:0]           stall_cnt
);

  logic [1:0]    w_src_en;
  logic [AW-1:0] w_src_addr [2];
  logic [DW-1:0] w_src_data [2];
  logic [DW-1:0] w_opnd     [2];
  logic [1:0]    w_load_hit;
  logic          w_stall_req;
  logic          w_bubble;

  logic            r_ex_valid;
  logic [31:0]     r_ex_pc;
  logic [DW-1:0]   r_ex_reg1;
  logic [DW-1:0]   r_ex_reg2;
  logic [OPW-1:0]  r_ex_aluop;
  logic [SELW-1:0] r_ex_alusel;
  logic [AW-1:0]   r_ex_waddr;
  logic            r_ex_wr_en;
  logic            r_ex_is_load;
  logic [15:0]     r_stall_cnt;

  assign w_src_en      = {reg2_rd_en, reg1_rd_en};
  assign w_src_addr[0] = reg1_addr;
  assign w_src_addr[1] = reg2_addr;
  assign w_src_data[0] = reg1_data;
  assign w_src_data[1] = reg2_data;

  // Channels are scanned oldest-to-youngest so the lowest matching index is the last write.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      w_opnd[n]     = w_src_data[n];
      w_load_hit[n] = 1'b0;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (fwd_wr_en[i] && (fwd_waddr[i*AW +: AW] == w_src_addr[n])) begin
          w_opnd[n]     = fwd_wdata[i*DW +: DW];
          w_load_hit[n] = (i < LOAD_STAGES) && fwd_is_load[i];
        end
      end
      if (!w_src_en[n]) begin
        w_opnd[n]     = imm;
        w_load_hit[n] = 1'b0;
      end else if (w_src_addr[n] == '0) begin
        w_opnd[n]     = '0;
        w_load_hit[n] = 1'b0;
      end
    end
  end

  assign w_stall_req = !rst && id_valid && (|w_load_hit);
  assign w_bubble    = flush || (!ex_stall && w_stall_req);

  assign stall_req = w_stall_req;
  assign id_ready  = !w_stall_req && !ex_stall;

  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_ex_valid   <= 1'b0;
      r_ex_pc      <= '0;
      r_ex_reg1    <= '0;
      r_ex_reg2    <= '0;
      r_ex_aluop   <= '0;
      r_ex_alusel  <= '0;
      r_ex_waddr   <= '0;
      r_ex_wr_en   <= 1'b0;
      r_ex_is_load <= 1'b0;
    end else if (!ex_stall) begin
      r_ex_valid   <= id_valid;
      r_ex_pc      <= id_pc;
      r_ex_reg1    <= w_opnd[0];
      r_ex_reg2    <= w_opnd[1];
      r_ex_aluop   <= dec_aluop;
      r_ex_alusel  <= dec_alusel;
      r_ex_waddr   <= dec_waddr;
      r_ex_wr_en   <= dec_wr_en && id_valid;
      r_ex_is_load <= dec_is_load && id_valid;
    end
  end

  // Only cycles that actually insert a load-use bubble are counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall_req && !ex_stall && !flush && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign ex_valid   = r_ex_valid;
  assign ex_pc      = r_ex_pc;
  assign ex_reg1    = r_ex_reg1;
  assign ex_reg2    = r_ex_reg2;
  assign ex_aluop   = r_ex_aluop;
  assign ex_alusel  = r_ex_alusel;
  assign ex_waddr   = r_ex_waddr;
  assign ex_wr_en   = r_ex_wr_en;
  assign ex_is_load = r_ex_is_load;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: directed vector table, multi-cycle corner sequences, and
// randomized traffic against a behavioural reference model.
module tb_id_operand_stage;
  localparam int LS = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic        reg1_rd_en, reg2_rd_en;
  logic [4:0]  reg1_addr, reg2_addr;
  logic [31:0] reg1_data, reg2_data, imm;
  logic [7:0]  dec_aluop;
  logic [2:0]  dec_alusel;
  logic [4:0]  dec_waddr;
  logic        dec_wr_en, dec_is_load;
  logic [1:0]  fwd_wr_en, fwd_is_load;
  logic [9:0]  fwd_waddr;
  logic [63:0] fwd_wdata;
  logic        ex_stall, flush;
  logic        stall_req, id_ready, ex_valid, ex_wr_en, ex_is_load;
  logic [31:0] ex_pc, ex_reg1, ex_reg2;
  logic [7:0]  ex_aluop;
  logic [2:0]  ex_alusel;
  logic [4:0]  ex_waddr;
  logic [15:0] stall_cnt;

  logic        ch_wen [2];
  logic        ch_ld  [2];
  logic [4:0]  ch_addr[2];
  logic [31:0] ch_dat [2];

  assign fwd_wr_en   = {ch_wen[1], ch_wen[0]};
  assign fwd_is_load = {ch_ld[1], ch_ld[0]};
  assign fwd_waddr   = {ch_addr[1], ch_addr[0]};
  assign fwd_wdata   = {ch_dat[1], ch_dat[0]};

  always #5 clk = ~clk;

  id_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .reg1_rd_en(reg1_rd_en), .reg2_rd_en(reg2_rd_en),
    .reg1_addr(reg1_addr), .reg2_addr(reg2_addr),
    .reg1_data(reg1_data), .reg2_data(reg2_data), .imm(imm),
    .dec_aluop(dec_aluop), .dec_alusel(dec_alusel), .dec_waddr(dec_waddr),
    .dec_wr_en(dec_wr_en), .dec_is_load(dec_is_load),
    .fwd_wr_en(fwd_wr_en), .fwd_is_load(fwd_is_load),
    .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .ex_stall(ex_stall), .flush(flush),
    .stall_req(stall_req), .id_ready(id_ready),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
    .ex_aluop(ex_aluop), .ex_alusel(ex_alusel), .ex_waddr(ex_waddr),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .stall_cnt(stall_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic wen, input logic ld,
                        input logic [4:0] a, input logic [31:0] d);
    ch_wen[i] = wen; ch_ld[i] = ld; ch_addr[i] = a; ch_dat[i] = d;
  endtask

  task automatic idle_inputs();
    rst = 0; id_valid = 0; id_pc = 0; reg1_rd_en = 0; reg2_rd_en = 0;
    reg1_addr = 0; reg2_addr = 0; reg1_data = 0; reg2_data = 0; imm = 0;
    dec_aluop = 0; dec_alusel = 0; dec_waddr = 0; dec_wr_en = 0; dec_is_load = 0;
    ex_stall = 0; flush = 0;
    for (int i = 0; i < 2; i++) set_ch(i, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    tick();
    @(negedge clk);
    rst = 0;
  endtask

  typedef struct {
    logic vld; logic e1; logic [4:0] a1; logic [31:0] d1;
    logic e2; logic [4:0] a2; logic [31:0] d2; logic [31:0] im;
    logic [1:0] wen; logic [1:0] isld;
    logic [4:0] w0; logic [31:0] f0; logic [4:0] w1; logic [31:0] f1;
    logic x_stall; logic x_vld; logic [31:0] x_r1; logic [31:0] x_r2;
  } vec_t;

  function automatic vec_t mk(logic vld, logic e1, logic [4:0] a1, logic [31:0] d1,
                              logic e2, logic [4:0] a2, logic [31:0] d2, logic [31:0] im,
                              logic [1:0] wen, logic [1:0] isld,
                              logic [4:0] w0, logic [31:0] f0, logic [4:0] w1, logic [31:0] f1,
                              logic xs, logic xv, logic [31:0] xr1, logic [31:0] xr2);
    vec_t v;
    v.vld = vld; v.e1 = e1; v.a1 = a1; v.d1 = d1; v.e2 = e2; v.a2 = a2; v.d2 = d2;
    v.im = im; v.wen = wen; v.isld = isld; v.w0 = w0; v.f0 = f0; v.w1 = w1; v.f1 = f1;
    v.x_stall = xs; v.x_vld = xv; v.x_r1 = xr1; v.x_r2 = xr2;
    return v;
  endfunction

  // Reference model state for the ID/EX register.
  logic        m_vld, m_we, m_ld;
  logic [31:0] m_pc, m_r1, m_r2;
  logic [7:0]  m_op;
  logic [2:0]  m_sel;
  logic [4:0]  m_wa;
  int          m_cnt;

  function automatic void mresolve(input logic en, input logic [4:0] a, input logic [31:0] rd,
                                   input logic [31:0] im, output logic [31:0] v, output logic h);
    bit found = 0;
    v = rd;
    h = 0;
    if (!en) v = im;
    else if (a == 0) v = 0;
    else begin
      for (int i = 0; i < 2; i++) begin
        if (!found && ch_wen[i] && ch_addr[i] == a) begin
          found = 1;
          v = ch_dat[i];
          h = (i < LS) && ch_ld[i];
        end
      end
    end
  endfunction

  task automatic model_step(output logic stall);
    logic [31:0] v1, v2;
    logic h1, h2;
    mresolve(reg1_rd_en, reg1_addr, reg1_data, imm, v1, h1);
    mresolve(reg2_rd_en, reg2_addr, reg2_data, imm, v2, h2);
    stall = !rst && id_valid && (h1 || h2);
    if (rst) begin
      m_vld = 0; m_we = 0; m_ld = 0; m_pc = 0; m_r1 = 0; m_r2 = 0;
      m_op = 0; m_sel = 0; m_wa = 0; m_cnt = 0;
    end else begin
      if (stall && !ex_stall && !flush && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (flush || (stall && !ex_stall)) begin
        m_vld = 0; m_we = 0; m_ld = 0; m_pc = 0; m_r1 = 0; m_r2 = 0;
        m_op = 0; m_sel = 0; m_wa = 0;
      end else if (!ex_stall) begin
        m_vld = id_valid; m_we = dec_wr_en && id_valid; m_ld = dec_is_load && id_valid;
        m_pc = id_pc; m_r1 = v1; m_r2 = v2; m_op = dec_aluop; m_sel = dec_alusel;
        m_wa = dec_waddr;
      end
    end
  endtask

  vec_t tbl[9];

  initial begin
    logic exp_stall;
    idle_inputs();
    rst = 1;

    //             vld e1 a1 d1          e2 a2 d2          imm         wen    isld   w0 f0          w1 f1          xs xv r1          r2
    tbl[0] = mk(1, 1, 3, 32'hAAAA, 0, 0, 32'h0,    32'h55,    2'b11, 2'b00, 3, 32'h1111, 3, 32'h2222, 0, 1, 32'h1111, 32'h55);
    tbl[1] = mk(1, 1, 0, 32'h7777, 1, 0, 32'h8888, 32'h0,     2'b01, 2'b00, 0, 32'hDEAD, 1, 32'h0,    0, 1, 32'h0,    32'h0);
    tbl[2] = mk(1, 1, 7, 32'h1234, 0, 7, 32'h0,    32'hFF,    2'b00, 2'b00, 7, 32'h5,    7, 32'h6,    0, 1, 32'h1234, 32'hFF);
    tbl[3] = mk(1, 1, 9, 32'h0,    1, 4, 32'h4444, 32'h0,     2'b10, 2'b10, 9, 32'h1,    9, 32'h9999, 0, 1, 32'h9999, 32'h4444);
    tbl[4] = mk(1, 1, 5, 32'h0,    1, 5, 32'h0,    32'h0,     2'b11, 2'b10, 5, 32'h5050, 5, 32'h6060, 0, 1, 32'h5050, 32'h5050);
    tbl[5] = mk(1, 0, 6, 32'h0,    1, 6, 32'h0,    32'h0,     2'b01, 2'b01, 6, 32'h6666, 0, 32'h0,    1, 0, 32'h0,    32'h0);
    tbl[6] = mk(0, 0, 0, 32'h0,    1, 6, 32'h0,    32'h33,    2'b01, 2'b01, 6, 32'h6666, 0, 32'h0,    0, 0, 32'h33,   32'h6666);
    tbl[7] = mk(1, 0, 6, 32'h0,    1, 2, 32'h2222, 32'h44,    2'b01, 2'b01, 6, 32'h6666, 2, 32'h0,    0, 1, 32'h44,   32'h2222);
    tbl[8] = mk(1, 1, 0, 32'h9,    0, 0, 32'h0,    32'h12,    2'b01, 2'b01, 0, 32'hBEEF, 0, 32'h0,    0, 1, 32'h0,    32'h12);

    // Reset state
    tick();
    #1;
    chk("rst_stall_req", stall_req, 0);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_pc", ex_pc, 0);
    chk("rst_ex_aluop", ex_aluop, 0);
    chk("rst_stall_cnt", stall_cnt, 0);

    // Directed vector table
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      rst = 0; ex_stall = 0; flush = 0;
      id_valid = tbl[k].vld; id_pc = 32'h1000 + k;
      reg1_rd_en = tbl[k].e1; reg1_addr = tbl[k].a1; reg1_data = tbl[k].d1;
      reg2_rd_en = tbl[k].e2; reg2_addr = tbl[k].a2; reg2_data = tbl[k].d2;
      imm = tbl[k].im; dec_wr_en = 1; dec_aluop = 8'h11; dec_alusel = 3'd2; dec_waddr = 5'd9;
      set_ch(0, tbl[k].wen[0], tbl[k].isld[0], tbl[k].w0, tbl[k].f0);
      set_ch(1, tbl[k].wen[1], tbl[k].isld[1], tbl[k].w1, tbl[k].f1);
      #1;
      chk($sformatf("tbl%0d_stall_req", k), stall_req, tbl[k].x_stall);
      chk($sformatf("tbl%0d_id_ready", k), id_ready, !tbl[k].x_stall);
      tick();
      chk($sformatf("tbl%0d_ex_valid", k), ex_valid, tbl[k].x_vld);
      chk($sformatf("tbl%0d_ex_wr_en", k), ex_wr_en, tbl[k].x_vld);
      chk($sformatf("tbl%0d_ex_reg1", k), ex_reg1, tbl[k].x_r1);
      chk($sformatf("tbl%0d_ex_reg2", k), ex_reg2, tbl[k].x_r2);
    end

    // Load-use: one bubble, then the load data forwards from channel 1
    do_reset();
    id_valid = 1; id_pc = 32'h40; reg1_rd_en = 1; reg1_addr = 5; dec_wr_en = 1;
    set_ch(0, 1, 1, 5, 32'h0);
    #1;
    chk("lu_stall_req", stall_req, 1);
    tick();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_wr_en", ex_wr_en, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    @(negedge clk);
    set_ch(0, 0, 0, 0, 0);
    set_ch(1, 1, 1, 5, 32'hABCD);
    #1;
    chk("lu_stall_clear", stall_req, 0);
    tick();
    chk("lu_ex_reg1", ex_reg1, 32'hABCD);
    chk("lu_ex_valid", ex_valid, 1);

    // EX backpressure holds the register and freezes the stall counter
    @(negedge clk);
    set_ch(1, 0, 0, 0, 0);
    id_pc = 32'h100; reg1_addr = 2; reg1_data = 32'h2020; dec_aluop = 8'h21; dec_waddr = 4;
    tick();
    chk("hold_load_pc", ex_pc, 32'h100);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ex_stall = 1; id_pc = 32'h200 + k; reg1_data = 32'h5A5A + k;
      set_ch(0, 1, 1, 2, 32'h0);
      #1;
      chk("hold_id_ready", id_ready, 0);
      tick();
      chk("hold_ex_pc", ex_pc, 32'h100);
      chk("hold_ex_reg1", ex_reg1, 32'h2020);
      chk("hold_ex_aluop", ex_aluop, 8'h21);
      chk("hold_stall_cnt", stall_cnt, 1);
    end

    // Flush wins over ex_stall
    @(negedge clk);
    set_ch(0, 0, 0, 0, 0);
    ex_stall = 1; flush = 1; id_valid = 1;
    tick();
    chk("flush_ex_valid", ex_valid, 0);
    chk("flush_ex_wr_en", ex_wr_en, 0);
    chk("flush_stall_cnt", stall_cnt, 1);

    // Reset during a load-use stall
    @(negedge clk);
    ex_stall = 0; flush = 0; id_pc = 32'h300;
    tick();
    chk("pre_rst_ex_pc", ex_pc, 32'h300);
    @(negedge clk);
    set_ch(0, 1, 1, 2, 32'h0);
    #1;
    chk("pre_rst_stall", stall_req, 1);
    rst = 1;
    #1;
    chk("rst_mid_stall_req", stall_req, 0);
    tick();
    chk("rst_mid_ex_valid", ex_valid, 0);
    chk("rst_mid_ex_pc", ex_pc, 0);
    chk("rst_mid_ex_reg1", ex_reg1, 0);
    chk("rst_mid_ex_waddr", ex_waddr, 0);
    chk("rst_mid_stall_cnt", stall_cnt, 0);

    // Counter saturation
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 65540; k++) @(posedge clk);
    #1;
    chk("sat_stall_cnt", stall_cnt, 32'hFFFF);
    chk("sat_ex_valid", ex_valid, 0);

    // Randomized traffic against the reference model
    @(negedge clk);
    idle_inputs();
    rst = 1;
    model_step(exp_stall);
    tick();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      rst = ($urandom_range(63) == 0);
      ex_stall = ($urandom_range(4) == 0);
      flush = ($urandom_range(7) == 0);
      id_valid = ($urandom_range(3) != 0);
      id_pc = $urandom;
      reg1_rd_en = $urandom_range(1); reg2_rd_en = $urandom_range(1);
      reg1_addr = $urandom_range(7); reg2_addr = $urandom_range(7);
      reg1_data = $urandom; reg2_data = $urandom; imm = $urandom;
      dec_aluop = $urandom; dec_alusel = $urandom; dec_waddr = $urandom;
      dec_wr_en = $urandom_range(1); dec_is_load = $urandom_range(1);
      for (int i = 0; i < 2; i++)
        set_ch(i, $urandom_range(1), $urandom_range(1), $urandom_range(7), $urandom);
      #1;
      model_step(exp_stall);
      chk("rnd_stall_req", stall_req, exp_stall);
      chk("rnd_id_ready", id_ready, !exp_stall && !ex_stall);
      tick();
      chk("rnd_ex_valid", ex_valid, m_vld);
      chk("rnd_ex_pc", ex_pc, m_pc);
      chk("rnd_ex_reg1", ex_reg1, m_r1);
      chk("rnd_ex_reg2", ex_reg2, m_r2);
      chk("rnd_ex_aluop", ex_aluop, m_op);
      chk("rnd_ex_alusel", ex_alusel, m_sel);
      chk("rnd_ex_waddr", ex_waddr, m_wa);
      chk("rnd_ex_wr_en", ex_wr_en, m_we);
      chk("rnd_ex_is_load", ex_is_load, m_ld);
      chk("rnd_stall_cnt", stall_cnt, m_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Parametrised successor to the ID-stage operand selector.
- Resolves both source operands across NUM_FWD forwarding channels (channel 0 = youngest, EX) and detects load-use hazards.
- Registers the result into the ID/EX pipeline register, with stall, bubble and flush control.
- Sits between the ID decoder and EX; replaces the fixed EX/MEM two-source forwarding.

Parameters:
- DW, 32, operand/data width.
- AW, 5, register address width.
- OPW, 8, aluop width.
- SELW, 3, alusel width.
- NUM_FWD, 2, number of forwarding channels, index 0 = youngest.
- LOAD_STAGES, 1, load data on channels 0..LOAD_STAGES-1 is not yet valid; a match on these stalls.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a decoded instruction.
- id_pc  in  32  PC of the ID instruction.
- reg1_rd_en, reg2_rd_en  in  1 each  operand read enables from the decoder.
- reg1_addr, reg2_addr  in  AW each  source register addresses.
- reg1_data, reg2_data  in  DW each  register file read data.
- imm  in  DW  immediate from the decoder.
- dec_aluop  in  OPW  decoded ALU operation.
- dec_alusel  in  SELW  decoded ALU result select.
- dec_waddr  in  AW  decoded destination address.
- dec_wr_en  in  1  decoded destination write enable.
- dec_is_load  in  1  decoded instruction is a load.
- fwd_wr_en  in  NUM_FWD  per-channel write enable.
- fwd_is_load  in  NUM_FWD  per-channel load flag.
- fwd_waddr  in  NUM_FWD*AW  per-channel destination address; channel i at [i*AW +: AW].
- fwd_wdata  in  NUM_FWD*DW  per-channel write data; channel i at [i*DW +: DW].
- ex_stall  in  1  EX cannot accept; hold the ID/EX register.
- flush  in  1  kill the instruction entering EX.
- stall_req  out  1  combinational; ID must hold (pc/if_id freeze).
- id_ready  out  1  combinational; equals !stall_req && !ex_stall.
- ex_valid, ex_pc, ex_reg1, ex_reg2, ex_aluop, ex_alusel, ex_waddr, ex_wr_en, ex_is_load  out  registered ID/EX fields.
- stall_cnt  out  16  saturating count of load-use stall cycles.

Behaviour:
- Operand resolution (combinational, per operand n):
  - rd_en=0 → imm.
  - rd_en=1 and addr==0 → 0; register 0 is never forwarded.
  - Otherwise the lowest-index channel i with fwd_wr_en[i] && fwd_waddr_i==addr supplies fwd_wdata_i.
  - No matching channel → regN_data.
- Hazard: stall_req=1 iff id_valid and, for some enabled operand with addr≠0, the lowest-index matching channel i has i<LOAD_STAGES and fwd_is_load[i]=1.
  - A younger non-load match masks an older load match.
  - stall_req=0 during rst.
- ID/EX register update each rising clk, in priority order:
  - rst=1 → all outputs 0: ex_valid=0, ex_wr_en=0, ex_is_load=0, ex_aluop=0 (NOP), ex_alusel=0, ex_waddr=0, ex_pc=0, ex_reg1=ex_reg2=0. stall_cnt=0.
  - flush=1 → bubble, regardless of ex_stall: ex_valid=0, ex_wr_en=0, ex_is_load=0, ex_aluop=0, ex_alusel=0. ex_pc/ex_reg*/ex_waddr don't-care but driven 0.
  - ex_stall=1 → hold all fields.
  - stall_req=1 → bubble as for flush.
  - else → load: ex_valid=id_valid, ex_wr_en=dec_wr_en&id_valid, ex_is_load=dec_is_load&id_valid, resolved operands, and pc/aluop/alusel/waddr from the inputs.
- Latency: one cycle from ID inputs to ex_* outputs.
- stall_cnt increments on each clk with stall_req=1 && !ex_stall && !flush; saturates at 16'hFFFF.
- A stall lasts exactly as long as the matching load stays in a channel below LOAD_STAGES; with the default, one bubble.
- Reset mid-stall: the bubble is not emitted, registers clear, and stall_req drops in the same cycle rst is high.

Test Plan:
- ex channel0 wr_en=1 waddr=3 wdata=32'h1111, channel1 waddr=3 wdata=32'h2222, reg1 addr=3 rd_en=1 → next cycle ex_reg1=32'h1111 (youngest wins).
- reg2_rd_en=1 addr=0, channel0 writes r0 with 32'hDEAD → ex_reg2=0; reg2_rd_en=0, imm=32'h0000_00FF → ex_reg2=32'hFF.
- Channel0 is_load=1 waddr=5, ID reads r5 → stall_req=1; next edge gives ex_valid=0, ex_wr_en=0, stall_cnt=1. Load moves to channel1 with wdata=32'hABCD → stall_req=0; next edge ex_reg1=32'hABCD.
- ex_stall=1 for 3 cycles while ID changes → ex_* hold the prior values and id_ready=0; with load hazard present, stall_cnt does not increment.
- flush=1 together with ex_stall=1 and a valid ID instruction → ex_valid=0 next cycle.
- rst=1 asserted during a load-use stall → next cycle all ex_* are 0, stall_cnt=0, stall_req=0; stall_cnt saturation checked by forcing 65 540 stall cycles → 16'hFFFF.
